// File: rtl/gpu_control_sequencer_pkg.sv
// Shared VGA command definitions: opcodes, sequencer state encoding and defaults
// used by the GPU control sequencer and anything that talks to it.
package gpu_control_sequencer_pkg;

  localparam logic [7:0] OP_NOP        = 8'h00;
  localparam logic [7:0] OP_SOFT_RESET = 8'h01;
  localparam logic [7:0] OP_START_VGA  = 8'h02;
  localparam logic [7:0] OP_STOP_VGA   = 8'h03;
  localparam logic [7:0] OP_SET_MODE   = 8'h04;
  localparam logic [7:0] OP_CLEAR_FB   = 8'h05;

  localparam int DEFAULT_NUM_MODES  = 3;
  localparam int DEFAULT_SYNC_DELAY = 8;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SYNC_START = 3'd1,
    ST_SYNC_WAIT  = 3'd2,
    ST_RUNNING    = 3'd3,
    ST_WAIT_ARG   = 3'd4,
    ST_CLEAR      = 3'd5
  } seq_state_e;

  function automatic logic is_known_opcode(input logic [7:0] op);
    return (op <= OP_CLEAR_FB);
  endfunction

  function automatic logic state_is_busy(input seq_state_e st);
    return (st == ST_SYNC_START) || (st == ST_SYNC_WAIT) ||
           (st == ST_WAIT_ARG)   || (st == ST_CLEAR);
  endfunction

endpackage

// File: rtl/gpu_control_sequencer_startup_delay_counter.sv
// Counts the cycles between the FIFO resync pulse and VGA enable; done is
// asserted while the count sits at SYNC_DELAY-1 and the count then holds.
module startup_delay_counter #(
  parameter int  SYNC_DELAY = 8,
  localparam int CW         = $clog2(SYNC_DELAY + 1)
) (
  input  logic system_clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic done
);

  logic [CW-1:0] r_count;

  assign done = (r_count == CW'(SYNC_DELAY - 1));

  always_ff @(posedge system_clock) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !done) begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/gpu_control_sequencer.sv
// Decodes MCU command bytes and sequences VGA start/stop, FIFO resync,
// framebuffer clear and video-mode selection. All outputs are registered.
module gpu_control_sequencer
  import gpu_control_sequencer_pkg::*;
#(
  parameter int  SYNC_DELAY = DEFAULT_SYNC_DELAY,
  parameter int  NUM_MODES  = DEFAULT_NUM_MODES,
  localparam int MODE_WIDTH = $clog2(NUM_MODES)
) (
  input  logic                  system_clock,
  input  logic                  reset_n,
  input  logic                  command_valid,
  input  logic [7:0]            command_byte,
  input  logic                  clear_done,
  output logic                  vga_enable,
  output logic                  fifo_sync_start,
  output logic                  clear_start,
  output logic [MODE_WIDTH-1:0] mode,
  output logic                  busy,
  output logic                  command_dropped,
  output logic                  command_error,
  output logic [2:0]            state_debug
);

  seq_state_e            r_state;
  logic                  r_vga_enable;
  logic                  r_fifo_sync_start;
  logic                  r_clear_start;
  logic [MODE_WIDTH-1:0] r_mode;
  logic                  r_busy;
  logic                  r_command_dropped;
  logic                  r_command_error;
  logic                  r_ret_running;

  seq_state_e            w_next_state;
  logic                  w_next_vga;
  logic [MODE_WIDTH-1:0] w_next_mode;
  logic                  w_next_ret;
  logic                  w_sync_pulse;
  logic                  w_clear_pulse;
  logic                  w_dropped;
  logic                  w_error;
  logic                  w_cmd;
  logic                  w_known;
  logic                  w_cnt_clear;
  logic                  w_cnt_enable;
  logic                  w_cnt_done;

  startup_delay_counter #(
    .SYNC_DELAY (SYNC_DELAY)
  ) u_delay (
    .system_clock (system_clock),
    .reset_n      (reset_n),
    .clear        (w_cnt_clear),
    .enable       (w_cnt_enable),
    .done         (w_cnt_done)
  );

  assign w_cnt_clear  = (r_state == ST_SYNC_START);
  assign w_cnt_enable = (r_state == ST_SYNC_WAIT);

  // In WAIT_ARG every byte is an argument, so opcode decoding is suppressed there.
  assign w_cmd   = command_valid && (r_state != ST_WAIT_ARG);
  assign w_known = is_known_opcode(command_byte);

  always_comb begin
    w_next_state  = r_state;
    w_next_vga    = r_vga_enable;
    w_next_mode   = r_mode;
    w_next_ret    = r_ret_running;
    w_sync_pulse  = 1'b0;
    w_clear_pulse = 1'b0;
    w_dropped     = 1'b0;
    w_error       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_cmd && w_known) begin
          case (command_byte)
            OP_START_VGA: begin
              w_next_state = ST_SYNC_START;
              w_sync_pulse = 1'b1;
            end
            OP_SET_MODE: w_next_state = ST_WAIT_ARG;
            OP_CLEAR_FB: begin
              w_next_state  = ST_CLEAR;
              w_clear_pulse = 1'b1;
              w_next_ret    = 1'b0;
            end
            default: ;
          endcase
        end
      end

      ST_SYNC_START, ST_SYNC_WAIT: begin
        if (r_state == ST_SYNC_START) begin
          w_next_state = ST_SYNC_WAIT;
        end else if (w_cnt_done) begin
          w_next_state = ST_RUNNING;
          w_next_vga   = 1'b1;
        end
        // A command in the same cycle as the delay expiring still wins for STOP.
        if (w_cmd && w_known) begin
          if (command_byte == OP_STOP_VGA) begin
            w_next_state = ST_IDLE;
            w_next_vga   = 1'b0;
          end else if (command_byte != OP_SOFT_RESET) begin
            w_dropped = 1'b1;
          end
        end
      end

      ST_RUNNING: begin
        if (w_cmd && w_known) begin
          case (command_byte)
            OP_STOP_VGA: begin
              w_next_state = ST_IDLE;
              w_next_vga   = 1'b0;
            end
            OP_CLEAR_FB: begin
              w_next_state  = ST_CLEAR;
              w_clear_pulse = 1'b1;
              w_next_ret    = 1'b1;
            end
            OP_SET_MODE: w_dropped = 1'b1;
            default: ;
          endcase
        end
      end

      ST_WAIT_ARG: begin
        if (command_valid) begin
          if ({24'd0, command_byte} < NUM_MODES) begin
            w_next_mode = command_byte[MODE_WIDTH-1:0];
          end else begin
            w_error = 1'b1;
          end
          w_next_state = ST_IDLE;
        end
      end

      ST_CLEAR: begin
        if (clear_done) begin
          w_next_state = r_ret_running ? ST_RUNNING : ST_IDLE;
        end
        if (w_cmd && w_known && (command_byte != OP_SOFT_RESET)) begin
          w_dropped = 1'b1;
        end
      end

      default: w_next_state = ST_IDLE;
    endcase

    if (w_cmd && !w_known) begin
      w_error = 1'b1;
    end

    // Soft reset overrides whatever the state-specific logic decided.
    if (w_cmd && (command_byte == OP_SOFT_RESET)) begin
      w_next_state  = ST_IDLE;
      w_next_vga    = 1'b0;
      w_next_mode   = '0;
      w_next_ret    = 1'b0;
      w_dropped     = 1'b0;
      w_sync_pulse  = 1'b0;
      w_clear_pulse = 1'b0;
    end
  end

  always_ff @(posedge system_clock) begin
    if (!reset_n) begin
      r_state           <= ST_IDLE;
      r_vga_enable      <= 1'b0;
      r_fifo_sync_start <= 1'b0;
      r_clear_start     <= 1'b0;
      r_mode            <= '0;
      r_busy            <= 1'b0;
      r_command_dropped <= 1'b0;
      r_command_error   <= 1'b0;
      r_ret_running     <= 1'b0;
    end else begin
      r_state           <= w_next_state;
      r_vga_enable      <= w_next_vga;
      r_fifo_sync_start <= w_sync_pulse;
      r_clear_start     <= w_clear_pulse;
      r_mode            <= w_next_mode;
      r_busy            <= state_is_busy(w_next_state);
      r_command_dropped <= w_dropped;
      r_command_error   <= w_error;
      r_ret_running     <= w_next_ret;
    end
  end

  assign vga_enable      = r_vga_enable;
  assign fifo_sync_start = r_fifo_sync_start;
  assign clear_start     = r_clear_start;
  assign mode            = r_mode;
  assign busy            = r_busy;
  assign command_dropped = r_command_dropped;
  assign command_error   = r_command_error;
  assign state_debug     = r_state;

endmodule

// File: doc/gpu_control_sequencer.md
Name: gpu_control_sequencer

Overview:
Parametrised successor to the top-level GPU start-up state machine. It decodes MCU command bytes, already synchronised into the system clock domain by the message broker, and sequences VGA start/stop, FIFO sync, framebuffer clear and video-mode selection. It sits between the message broker (command path) and the vga / pixel_memory instances. Unlike the current fixed start-up FSM, it supports multiple commands, stop and abort, soft reset, argument-carrying commands and a configurable sync delay.

Parameters:
SYNC_DELAY, 8, cycles between the fifo_sync_start pulse and vga_enable assertion; must be >= 1.
NUM_MODES, 3, number of legal video modes; must be >= 2.
MODE_WIDTH, $clog2(NUM_MODES), width of the mode output; derived, not overridden.

Ports:
system_clock  input  1  sole clock, rising edge
reset_n  input  1  synchronous active-low reset
command_valid  input  1  one-cycle strobe: command_byte is valid this cycle
command_byte  input  8  opcode or argument byte
clear_done  input  1  one-cycle strobe from pixel memory: clear finished
vga_enable  output  1  level: enables the VGA timing generator
fifo_sync_start  output  1  one-cycle pulse: resynchronise the pixel FIFO
clear_start  output  1  one-cycle pulse: start framebuffer clear
mode  output  MODE_WIDTH  current video mode
busy  output  1  high in SYNC_START, SYNC_WAIT, WAIT_ARG or CLEAR
command_dropped  output  1  one-cycle pulse: a valid command was ignored
command_error  output  1  one-cycle pulse: unknown opcode or illegal mode argument
state_debug  output  3  current state encoding

Behaviour:
- Reset (reset_n=0 at a clock edge): state=IDLE; mode=0; all other outputs 0. Reset takes priority over every other input.
- All outputs are registered. Pulses are exactly 1 cycle wide.
- Opcodes: NOP=0x00, SOFT_RESET=0x01, START_VGA=0x02, STOP_VGA=0x03, SET_MODE=0x04 (followed by 1 argument byte), CLEAR_FB=0x05. Any other value is unknown: command_error pulse, no state change, in every state except WAIT_ARG.
- SOFT_RESET (all states except WAIT_ARG): next cycle state=IDLE, vga_enable=0, mode=0. Abandons any sync or clear in progress.
- IDLE:
  - START_VGA -> SYNC_START.
  - SET_MODE -> WAIT_ARG.
  - CLEAR_FB -> CLEAR with clear_start pulse; ret_running=0.
  - STOP_VGA and NOP: no effect.
- SYNC_START: fifo_sync_start=1 for this single cycle; counter cleared; next state SYNC_WAIT.
- SYNC_WAIT: counter increments each cycle. When counter==SYNC_DELAY-1, go to RUNNING and set vga_enable=1.
  - Latency: START_VGA sampled at cycle T gives fifo_sync_start high at T+1 and vga_enable high at T+2+SYNC_DELAY.
- SYNC_START and SYNC_WAIT command handling:
  - STOP_VGA aborts to IDLE; vga_enable stays 0.
  - SOFT_RESET behaves as above.
  - Any other valid opcode pulses command_dropped.
- RUNNING:
  - STOP_VGA -> IDLE, with vga_enable=0 on the next cycle.
  - CLEAR_FB -> CLEAR with clear_start pulse; ret_running=1; vga_enable stays 1.
  - START_VGA and NOP: no effect.
  - SET_MODE: command_dropped pulse. The mode may only change while stopped.
- WAIT_ARG: the next command_valid byte is always the argument, including 0x01.
  - Argument < NUM_MODES: mode=argument[MODE_WIDTH-1:0]. Compare all 8 bits.
  - Otherwise: command_error pulse; mode unchanged.
  - Either way, return to IDLE. No timeout.
- CLEAR:
  - Waits for clear_done, then returns to RUNNING if ret_running=1, else IDLE.
  - Commands other than SOFT_RESET pulse command_dropped. This includes a command arriving in the same cycle as clear_done: clear_done is processed and the command is dropped.
  - clear_done outside CLEAR is ignored.
- command_valid=0 means command_byte is ignored.

Decomposition:
- Shared package/include (vga_commands): opcode constants, state encodings (IDLE=0, SYNC_START=1, SYNC_WAIT=2, RUNNING=3, WAIT_ARG=4, CLEAR=5), and the default NUM_MODES.
- One natural sub-module: startup_delay_counter (parameter SYNC_DELAY; inputs clear and enable; output done at count SYNC_DELAY-1; counter width $clog2(SYNC_DELAY+1)).
- The FSM, pulse registers and mode register stay in gpu_control_sequencer.

Test Plan:
- Reset, then START_VGA at T with SYNC_DELAY=8 -> fifo_sync_start high only at T+1; vga_enable rises at T+10; busy high for T+1..T+9.
- START_VGA, then STOP_VGA during SYNC_WAIT -> IDLE the next cycle, vga_enable never rises; a later START_VGA re-runs the full sequence.
- In IDLE, SET_MODE then 0x02 -> mode=2. SET_MODE then 0x03 (NUM_MODES=3) -> command_error pulse, mode stays 2. SET_MODE then 0x01 -> mode=1 and no soft reset.
- In RUNNING, CLEAR_FB -> clear_start pulse, vga_enable stays 1. CLEAR_FB again during CLEAR -> command_dropped. clear_done -> back to RUNNING. Repeat from IDLE -> back to IDLE.
- Opcode 0x7F in IDLE and in RUNNING -> command_error pulse, no state change. SET_MODE in RUNNING -> command_dropped, mode unchanged.
- reset_n low mid SYNC_WAIT, then SOFT_RESET in RUNNING with mode=2 -> all outputs 0, mode=0, state_debug=0 on the following cycle.
